// File: rtl/irq_ctrl_if.sv
// Bus between the CPU side and the interrupt controller: request pulses, mask
// writes and the ack/eoi handshake in one direction, controller status in the other.
interface irq_ctrl_if #(
  parameter int unsigned N_IRQ = 8
);
  localparam int unsigned ID_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  logic [N_IRQ-1:0] irq_in;
  logic             we;
  logic [N_IRQ-1:0] wdata;
  logic             ack;
  logic             eoi;
  logic             irq;
  logic [9:0]       vector;
  logic [ID_W-1:0]  id;
  logic [N_IRQ-1:0] pending;
  logic [N_IRQ-1:0] mask;
  logic             in_service;
  logic             ovf;

  modport master (
    output irq_in, we, wdata, ack, eoi,
    input  irq, vector, id, pending, mask, in_service, ovf
  );

  modport slave (
    input  irq_in, we, wdata, ack, eoi,
    output irq, vector, id, pending, mask, in_service, ovf
  );
endinterface

// File: rtl/irq_ctrl.sv
// Fixed-priority interrupt controller: latches request pulses, arbitrates the
// lowest enabled index and runs an IDLE/REQ/SERVICE handshake with the CPU.
module irq_ctrl #(
  parameter int unsigned N_IRQ    = 8,
  parameter logic [9:0]  VEC_BASE = 10'h3F0
) (
  input logic       clk,
  input logic       reset,
  irq_ctrl_if.slave bus
);
  localparam int unsigned ID_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_e;

  state_e           state_q, state_d;
  logic [N_IRQ-1:0] pending_q, pending_d;
  logic [N_IRQ-1:0] mask_q, mask_d;
  logic [N_IRQ-1:0] clr;
  logic [N_IRQ-1:0] req;
  logic [ID_W-1:0]  id_q, id_d;
  logic [ID_W-1:0]  win_id;
  logic             win_vld;
  logic             irq_q, irq_d;
  logic             in_service_q, in_service_d;
  logic             ovf_q, ovf_d;
  logic [9:0]       vector_q, vector_d;

  assign req = pending_q & mask_q;

  // Lowest set index wins: scan downward so the last hit is the smallest.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        win_vld = 1'b1;
        win_id  = ID_W'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    clr     = '0;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d = REQ;
          id_d    = win_id;
        end
      end
      REQ: begin
        // ack takes precedence over both eoi and a withdrawn mask bit
        if (bus.ack) begin
          state_d  = SERVICE;
          clr[id_q] = 1'b1;
        end else if (!mask_q[id_q]) begin
          state_d = IDLE;
        end
      end
      SERVICE: begin
        if (bus.eoi) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A pulse on the same edge as its clear wins, so it never counts as lost.
  always_comb begin
    pending_d    = (pending_q & ~clr) | bus.irq_in;
    mask_d       = bus.we ? bus.wdata : mask_q;
    ovf_d        = (ovf_q & ~bus.we) | (|(bus.irq_in & pending_q & ~clr));
    irq_d        = (state_d == REQ);
    in_service_d = (state_d == SERVICE);
    vector_d     = VEC_BASE + 10'(id_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      pending_q    <= '0;
      mask_q       <= '0;
      id_q         <= '0;
      irq_q        <= 1'b0;
      in_service_q <= 1'b0;
      ovf_q        <= 1'b0;
      vector_q     <= VEC_BASE;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      mask_q       <= mask_d;
      id_q         <= id_d;
      irq_q        <= irq_d;
      in_service_q <= in_service_d;
      ovf_q        <= ovf_d;
      vector_q     <= vector_d;
    end
  end

  assign bus.irq        = irq_q;
  assign bus.in_service = in_service_q;
  assign bus.id         = id_q;
  assign bus.vector     = vector_q;
  assign bus.pending    = pending_q;
  assign bus.mask       = mask_q;
  assign bus.ovf        = ovf_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed scenarios followed by random traffic, all
// outputs compared every cycle against a behavioural model.
module tb_irq_ctrl;
  localparam int unsigned N = 8;
  localparam int unsigned BASE = 32'h3F0;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  irq_ctrl_if #(.N_IRQ(N)) bus ();

  irq_ctrl #(.N_IRQ(N), .VEC_BASE(10'h3F0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // model: 0 = waiting, 1 = offering to CPU, 2 = handler running
  int m_phase;
  bit m_pend[N];
  bit m_mask[N];
  int m_id;
  bit m_ovf;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
  endtask

  function automatic logic [31:0] pack(input bit v[N]);
    logic [31:0] r = 0;
    for (int i = 0; i < int'(N); i++) r[i] = v[i];
    return r;
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_id    = 0;
    m_ovf   = 0;
    for (int i = 0; i < int'(N); i++) begin
      m_pend[i] = 0;
      m_mask[i] = 0;
    end
  endtask

  task automatic model_edge(input logic [N-1:0] in, input logic we, input logic [N-1:0] wd,
                            input logic ack, input logic eoi);
    int  nphase = m_phase;
    int  nid    = m_id;
    int  cleared = -1;
    bit  lost = 0;
    if (m_phase == 0) begin
      for (int i = int'(N) - 1; i >= 0; i--)
        if (m_pend[i] && m_mask[i]) begin nphase = 1; nid = i; end
    end else if (m_phase == 1) begin
      if (ack) begin nphase = 2; cleared = m_id; end
      else if (!m_mask[m_id]) nphase = 0;
    end else if (eoi) begin
      nphase = 0;
    end
    for (int i = 0; i < int'(N); i++) begin
      if (in[i] && m_pend[i] && i != cleared) lost = 1;
      if (in[i]) m_pend[i] = 1;
      else if (i == cleared) m_pend[i] = 0;
    end
    m_ovf = (m_ovf && !we) || lost;
    if (we) for (int i = 0; i < int'(N); i++) m_mask[i] = wd[i];
    m_phase = nphase;
    m_id    = nid;
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".irq"},        32'(bus.irq),        32'(m_phase == 1));
    check({tag, ".in_service"}, 32'(bus.in_service), 32'(m_phase == 2));
    check({tag, ".id"},         32'(bus.id),         32'(m_id));
    check({tag, ".vector"},     32'(bus.vector),     (BASE + 32'(m_id)) % 1024);
    check({tag, ".pending"},    32'(bus.pending),    pack(m_pend));
    check({tag, ".mask"},       32'(bus.mask),       pack(m_mask));
    check({tag, ".ovf"},        32'(bus.ovf),        32'(m_ovf));
  endtask

  // One clock: present inputs, advance the model, sample 1ns after the edge.
  task automatic tick(input string tag, input logic [N-1:0] in, input logic we,
                      input logic [N-1:0] wd, input logic ack, input logic eoi);
    bus.irq_in = in; bus.we = we; bus.wdata = wd; bus.ack = ack; bus.eoi = eoi;
    @(posedge clk);
    if (reset) model_reset();
    else model_edge(in, we, wd, ack, eoi);
    #1;
    compare_all(tag);
    bus.irq_in = '0; bus.we = 0; bus.wdata = '0; bus.ack = 0; bus.eoi = 0;
  endtask

  task automatic idle(input string tag);
    tick(tag, '0, 0, '0, 0, 0);
  endtask

  initial begin
    bus.irq_in = '0; bus.we = 0; bus.wdata = '0; bus.ack = 0; bus.eoi = 0;
    reset = 1;
    model_reset();
    // pulses and handshakes under reset must be dropped
    tick("rst0", 8'hFF, 1, 8'hFF, 1, 1);
    tick("rst1", 8'h5A, 0, '0, 0, 0);
    reset = 0;
    idle("rst_rel");
    check("rst.vector", 32'(bus.vector), 32'h3F0);

    // basic service flow on line 7
    tick("b.mask", '0, 1, 8'h80, 0, 0);
    tick("b.pulse", 8'h80, 0, '0, 0, 0);
    check("b.pend_e0", 32'(bus.pending), 32'h80);
    check("b.irq_e0", 32'(bus.irq), 32'h0);
    idle("b.arb");
    check("b.irq", 32'(bus.irq), 32'h1);
    check("b.id", 32'(bus.id), 32'h7);
    check("b.vec", 32'(bus.vector), 32'h3F7);
    tick("b.ack", '0, 0, '0, 1, 0);
    check("b.pend_clr", 32'(bus.pending), 32'h0);
    check("b.insvc", 32'(bus.in_service), 32'h1);
    tick("b.eoi", '0, 0, '0, 0, 1);
    check("b.insvc_off", 32'(bus.in_service), 32'h0);

    // priority: line 2 before line 7, no preemption by 7 meanwhile
    tick("p.mask", '0, 1, 8'hFF, 0, 0);
    tick("p.pulse", 8'h84, 0, '0, 0, 0);
    idle("p.arb");
    check("p.id_first", 32'(bus.id), 32'h2);
    tick("p.ack", '0, 0, '0, 1, 1);
    tick("p.eoi", '0, 0, '0, 0, 1);
    idle("p.arb2");
    check("p.id_second", 32'(bus.id), 32'h7);
    check("p.vec_second", 32'(bus.vector), 32'h3F7);
    tick("p.ack2", '0, 0, '0, 1, 0);
    tick("p.eoi2", '0, 0, '0, 0, 1);

    // masked request waits until the mask opens
    tick("m.mask0", '0, 1, 8'h00, 0, 0);
    tick("m.pulse", 8'h08, 0, '0, 0, 0);
    idle("m.wait1");
    idle("m.wait2");
    check("m.irq_masked", 32'(bus.irq), 32'h0);
    check("m.pend", 32'(bus.pending), 32'h08);
    tick("m.open", '0, 1, 8'h08, 0, 0);
    idle("m.arb");
    check("m.irq", 32'(bus.irq), 32'h1);
    check("m.id", 32'(bus.id), 32'h3);
    tick("m.ack", '0, 0, '0, 1, 0);
    tick("m.eoi", '0, 0, '0, 0, 1);

    // overflow, clear by write, and set winning over the ack clear
    tick("o.mask0", '0, 1, 8'h00, 0, 0);
    tick("o.p1", 8'h02, 0, '0, 0, 0);
    tick("o.p2", 8'h02, 0, '0, 0, 0);
    check("o.ovf_set", 32'(bus.ovf), 32'h1);
    tick("o.wr", '0, 1, 8'h02, 0, 0);
    check("o.ovf_clr", 32'(bus.ovf), 32'h0);
    idle("o.arb");
    tick("o.ack_set", 8'h02, 0, '0, 1, 0);
    check("o.pend_kept", 32'(bus.pending), 32'h02);
    check("o.no_ovf", 32'(bus.ovf), 32'h0);
    tick("o.eoi", '0, 0, '0, 0, 1);
    idle("o.arb2");
    tick("o.ack2", '0, 0, '0, 1, 0);
    tick("o.eoi2", '0, 0, '0, 0, 1);

    // withdrawal while offered
    tick("w.mask", '0, 1, 8'hFF, 0, 0);
    tick("w.pulse", 8'h10, 0, '0, 0, 0);
    idle("w.arb");
    tick("w.close", '0, 1, 8'h00, 0, 0);
    idle("w.drop");
    check("w.irq_off", 32'(bus.irq), 32'h0);
    check("w.pend_kept", 32'(bus.pending), 32'h10);

    // reset in the middle of a handler
    tick("r.open", '0, 1, 8'hFF, 0, 0);
    idle("r.arb");
    tick("r.ack", '0, 0, '0, 1, 0);
    #2 reset = 1;
    #1;
    model_reset();
    compare_all("r.async");
    tick("r.hold", 8'h01, 0, '0, 0, 1);
    reset = 0;
    tick("r.late_eoi", '0, 0, '0, 0, 1);
    check("r.insvc", 32'(bus.in_service), 32'h0);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      logic [N-1:0] in;
      logic [N-1:0] wd;
      logic we;
      logic ack;
      logic eoi;
      in  = N'($urandom) & N'($urandom) & N'($urandom);
      we  = ($urandom_range(0, 11) == 0);
      wd  = N'($urandom);
      ack = ($urandom_range(0, 2) == 0);
      eoi = ($urandom_range(0, 2) == 0);
      reset = ($urandom_range(0, 249) == 0);
      tick("rnd", in, we, wd, ack, eoi);
    end
    reset = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
